neuron_layer_sched: RTL

- Time-multiplexes one `neuron` datapath instance across NUM_OUTPUTS output neurons for one SNN timestep.
- For each output neuron j, in order:
  - loads v_mem from membrane RAM;
  - accumulates the signed weight of every spiking input;
  - applies leak/threshold;
  - writes the result back and records the output spike.
- Sits between the Wishbone-loaded weight/membrane RAMs and the layer spike registers; started once per timestep by the top-level sequencer.

---
 rtl/snn_pkg.sv | 22 ++
 rtl/neuron.sv | 41 ++++
 rtl/neuron_layer_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN layer scheduler and its neuron datapath.
package snn_pkg;

    localparam int SIZE_DEF = 8;
    localparam int SIGN_BIT = SIZE_DEF - 1;

    typedef enum logic [2:0] {
        IDLE,
        VM_RD,
        VM_LD,
        SCAN,
        ACC,
        DECAY,
        WB,
        DONE
    } state_t;

    localparam state_t STATE_RST = IDLE;
    localparam logic   FSEL_ACC  = 1'b0;
    localparam logic   FSEL_LEAK = 1'b1;

endpackage

// File: rtl/neuron.sv
// Combinational LIF neuron datapath: sign-magnitude weight accumulate (clamped at 0)
// or leak-and-fire with reset-to-zero on spike.
module neuron
    import snn_pkg::*;
#(
    parameter int SIZE = SIZE_DEF,
    parameter int SIGN = SIGN_BIT
) (
    input  logic            function_sel,
    input  logic [SIZE-1:0] weight,
    input  logic [SIZE-1:0] v_mem_in,
    input  logic [SIZE-1:0] beta,
    input  logic [SIZE-1:0] v_th,
    output logic [SIZE-1:0] v_mem_out,
    output logic            spike
);

    logic [SIZE-1:0] mag;
    logic [SIZE-1:0] decay;
    logic [SIZE-1:0] frac_unused;

    assign mag = SIZE'(weight[SIGN-1:0]);
    // Only the integer part of v*beta/2^SIZE is kept; the fraction is dropped.
    assign {decay, frac_unused} = (2*SIZE)'(v_mem_in) * (2*SIZE)'(beta);

    always_comb begin
        v_mem_out = v_mem_in;
        spike     = 1'b0;
        if (function_sel == FSEL_ACC) begin
            if (weight[SIGN]) begin
                v_mem_out = (v_mem_in < mag) ? '0 : v_mem_in - mag;
            end else begin
                v_mem_out = v_mem_in + mag;
            end
        end else begin
            spike     = (decay > v_th);
            v_mem_out = spike ? '0 : decay;
        end
    end

endmodule

// File: rtl/neuron_layer_sched.sv
// Time-multiplexes one neuron datapath over NUM_OUTPUTS neurons for one SNN timestep,
// streaming weights and membrane values through single-cycle-latency RAMs.
module neuron_layer_sched
    import snn_pkg::*;
#(
    parameter int SIZE        = SIZE_DEF,
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_OUTPUTS = 8,
    parameter int W_AW        = $clog2(NUM_INPUTS * NUM_OUTPUTS),
    parameter int V_AW        = $clog2(NUM_OUTPUTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_INPUTS-1:0]  in_spikes,
    input  logic [SIZE-1:0]        beta,
    input  logic [SIZE-1:0]        v_th,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_OUTPUTS-1:0] out_spikes,
    output logic                   w_rd_en,
    output logic [W_AW-1:0]        w_addr,
    input  logic [SIZE-1:0]        w_rdata,
    output logic                   vm_rd_en,
    output logic                   vm_wr_en,
    output logic [V_AW-1:0]        vm_addr,
    input  logic [SIZE-1:0]        vm_rdata,
    output logic [SIZE-1:0]        vm_wdata
);

    localparam int I_AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [I_AW-1:0] LAST_I = I_AW'(NUM_INPUTS - 1);
    localparam logic [V_AW-1:0] LAST_J = V_AW'(NUM_OUTPUTS - 1);

    state_t                 state_q, state_d;
    logic [V_AW-1:0]        j_q, j_d;
    logic [I_AW-1:0]        i_q, i_d;
    logic [SIZE-1:0]        acc_q, acc_d;
    logic [NUM_INPUTS-1:0]  spk_q, spk_d;
    logic [SIZE-1:0]        beta_q, beta_d;
    logic [SIZE-1:0]        vth_q, vth_d;
    logic [NUM_OUTPUTS-1:0] out_spikes_q, out_spikes_d;

    logic [SIZE-1:0]        n_v_out;
    logic                   n_spike;
    logic                   n_fsel;

    assign n_fsel = (state_q == DECAY) ? FSEL_LEAK : FSEL_ACC;

    neuron #(
        .SIZE (SIZE),
        .SIGN (SIZE - 1)
    ) u_neuron (
        .function_sel (n_fsel),
        .weight       (w_rdata),
        .v_mem_in     (acc_q),
        .beta         (beta_q),
        .v_th         (vth_q),
        .v_mem_out    (n_v_out),
        .spike        (n_spike)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        j_d          = j_q;
        i_d          = i_q;
        acc_d        = acc_q;
        spk_d        = spk_q;
        beta_d       = beta_q;
        vth_d        = vth_q;
        out_spikes_d = out_spikes_q;
        busy         = (state_q != IDLE);
        done         = 1'b0;
        w_rd_en      = 1'b0;
        w_addr       = '0;
        vm_rd_en     = 1'b0;
        vm_wr_en     = 1'b0;
        vm_addr      = '0;
        vm_wdata     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    spk_d        = in_spikes;
                    beta_d       = beta;
                    vth_d        = v_th;
                    out_spikes_d = '0;
                    j_d          = '0;
                    state_d      = VM_RD;
                end
            end
            VM_RD: begin
                vm_rd_en = 1'b1;
                vm_addr  = j_q;
                state_d  = VM_LD;
            end
            VM_LD: begin
                acc_d   = vm_rdata;
                i_d     = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (spk_q[i_q]) begin
                    w_rd_en = 1'b1;
                    w_addr  = W_AW'(j_q) * W_AW'(NUM_INPUTS) + W_AW'(i_q);
                    state_d = ACC;
                end else if (i_q == LAST_I) begin
                    state_d = DECAY;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            ACC: begin
                acc_d = n_v_out;
                if (i_q == LAST_I) begin
                    state_d = DECAY;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = SCAN;
                end
            end
            DECAY: begin
                out_spikes_d[j_q] = n_spike;
                acc_d             = n_v_out;
                state_d           = WB;
            end
            WB: begin
                vm_wr_en = 1'b1;
                vm_addr  = j_q;
                vm_wdata = acc_q;
                if (j_q == LAST_J) begin
                    state_d = DONE;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = VM_RD;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge; strobes decode from state, so IDLE silences the RAMs at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= STATE_RST;
            j_q          <= '0;
            i_q          <= '0;
            acc_q        <= '0;
            spk_q        <= '0;
            beta_q       <= '0;
            vth_q        <= '0;
            out_spikes_q <= '0;
        end else begin
            state_q      <= state_d;
            j_q          <= j_d;
            i_q          <= i_d;
            acc_q        <= acc_d;
            spk_q        <= spk_d;
            beta_q       <= beta_d;
            vth_q        <= vth_d;
            out_spikes_q <= out_spikes_d;
        end
    end

    assign out_spikes = out_spikes_q;

endmodule
